// File: rtl/fcpu_pkg.sv
// Core-wide widths and the common data bus packet layout.
package fcpu_pkg;

    localparam int unsigned RSV_ID_W = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CDB_W    = RSV_ID_W + DATA_W;

    typedef struct packed {
        logic [RSV_ID_W-1:0] rsv_id;
        logic [DATA_W-1:0]   data;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit request bus and CDB broadcast bundle for the CDB arbiter.
interface cdb_arbiter_if
    import fcpu_pkg::*;
#(
    parameter int unsigned N_UNITS = 4
);
    localparam int unsigned UNIT_W = $clog2(N_UNITS);

    logic [N_UNITS*CDB_W-1:0] req_cdb;
    logic [N_UNITS-1:0]       req_valid;
    logic [N_UNITS-1:0]       req_ready;
    logic                     stall;
    cdb_pkt_t                 cdb;
    logic                     cdb_valid;
    logic [UNIT_W-1:0]        last_unit;

    // Requester / pipeline-control side
    modport master (
        output req_cdb, req_valid, stall,
        input  req_ready, cdb, cdb_valid, last_unit
    );

    // Arbiter side
    modport slave (
        input  req_cdb, req_valid, stall,
        output req_ready, cdb, cdb_valid, last_unit
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: first valid index at or after ptr, wrapping, as one-hot and index.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant_c,
    output logic [$clog2(N)-1:0] winner_c,
    output logic                 any_c
);
    localparam int unsigned W = $clog2(N);

    always_comb begin
        grant_c  = '0;
        winner_c = '0;
        any_c    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned idx;
            logic [W-1:0] sel;
            idx = 32'(ptr) + i;
            if (idx >= N) idx = idx - N;
            sel = W'(idx);
            if (!any_c && valid[sel]) begin
                any_c         = 1'b1;
                winner_c      = sel;
                grant_c[sel]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among functional units;
// the winning packet is broadcast from a register one cycle after the grant.
module cdb_arbiter
    import fcpu_pkg::*;
#(
    parameter int unsigned N_UNITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    localparam int unsigned UNIT_W = $clog2(N_UNITS);

    logic [N_UNITS-1:0] valid_c;
    logic [N_UNITS-1:0] grant_c;
    logic [UNIT_W-1:0]  winner_c;
    logic               any_c;
    cdb_pkt_t           pkts [N_UNITS];

    logic [UNIT_W-1:0]  ptr_q, ptr_d;
    cdb_pkt_t           cdb_q, cdb_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [UNIT_W-1:0]  last_unit_q, last_unit_d;

    for (genvar g = 0; g < N_UNITS; g++) begin : g_unpack
        assign pkts[g] = cdb_pkt_t'(bus.req_cdb[g*CDB_W +: CDB_W]);
    end

    // Reset and stall mask every request, so nothing is accepted in those cycles
    assign valid_c = (rst || bus.stall) ? '0 : bus.req_valid;

    rr_pick #(.N(N_UNITS)) u_pick (
        .valid    (valid_c),
        .ptr      (ptr_q),
        .grant_c  (grant_c),
        .winner_c (winner_c),
        .any_c    (any_c)
    );

    assign bus.req_ready = grant_c;
    assign bus.cdb       = cdb_q;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.last_unit = last_unit_q;

    always_comb begin
        ptr_d       = ptr_q;
        cdb_d       = cdb_q;
        cdb_valid_d = 1'b0;
        last_unit_d = last_unit_q;
        if (any_c) begin
            ptr_d       = (winner_c == UNIT_W'(N_UNITS - 1)) ? '0 : winner_c + UNIT_W'(1);
            cdb_d       = pkts[winner_c];
            cdb_valid_d = 1'b1;
            last_unit_d = winner_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
            last_unit_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cdb_q       <= cdb_d;
            cdb_valid_q <= cdb_valid_d;
            last_unit_q <= last_unit_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, rotation, wrap/skip, stall, idle hold, mid-op reset.
module tb_cdb_arbiter;
    import fcpu_pkg::*;

    localparam int unsigned N = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    cdb_pkt_t pkt [N];

    cdb_arbiter_if #(.N_UNITS(N)) bus ();

    cdb_arbiter #(.N_UNITS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic cdb_pkt_t mk(input int unsigned tag, input logic [31:0] data);
        cdb_pkt_t p;
        p.rsv_id = RSV_ID_W'(tag);
        p.data   = DATA_W'(data);
        return p;
    endfunction

    // Drive the request vector and let the combinational grant settle
    task automatic drive(input logic [N-1:0] valid);
        logic [N*CDB_W-1:0] v;
        for (int i = 0; i < N; i++) v[i*CDB_W +: CDB_W] = pkt[i];
        bus.req_cdb   = v;
        bus.req_valid = valid;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic vld, input int unsigned unit, input cdb_pkt_t p);
        check_eq({tag, "_cdb_valid"}, 64'(bus.cdb_valid), 64'(vld));
        check_eq({tag, "_last_unit"}, 64'(bus.last_unit), 64'(unit));
        check_eq({tag, "_cdb"},       64'(bus.cdb),       64'(p));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        bus.stall = 1'b0;
        rst       = 1'b1;
        for (int i = 0; i < N; i++) pkt[i] = mk(i, 32'h10 + 32'(i));
        drive(4'b1111);

        // Reset with every unit requesting
        check_eq("rst_ready", 64'(bus.req_ready), 64'h0);
        tick();
        check_out("rst", 1'b0, 0, '0);
        check_eq("rst_ready_post", 64'(bus.req_ready), 64'h0);
        rst = 1'b0;
        #1;
        check_eq("first_grant", 64'(bus.req_ready), 64'b0001);

        // Rotation across all units
        for (int k = 0; k < 8; k++) begin
            check_eq("rot_ready", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            check_out("rot", 1'b1, k % 4, mk(k % 4, 32'h10 + 32'(k % 4)));
        end

        // Wrap/skip: park ptr at 3 via a lone unit-2 grant
        drive(4'b0100);
        check_eq("park_ready", 64'(bus.req_ready), 64'b0100);
        tick();
        drive(4'b0110);
        check_eq("wrap_ready", 64'(bus.req_ready), 64'b0010);
        tick();
        check_out("wrap", 1'b1, 1, mk(1, 32'h11));
        check_eq("skip_ready", 64'(bus.req_ready), 64'b0100);
        tick();
        check_out("skip", 1'b1, 2, mk(2, 32'h12));
        drive(4'b1001);
        check_eq("ptr3_ready", 64'(bus.req_ready), 64'b1000);
        drive(4'b0000);
        check_eq("idle_ready", 64'(bus.req_ready), 64'h0);
        tick();
        check_out("idle", 1'b0, 2, mk(2, 32'h12));

        // Stall blocks all grants and freezes ptr (=3)
        bus.stall = 1'b1;
        drive(4'b0101);
        for (int k = 0; k < 3; k++) begin
            check_eq("stall_ready", 64'(bus.req_ready), 64'h0);
            tick();
            check_eq("stall_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        end
        bus.stall = 1'b0;
        #1;
        check_eq("release_ready", 64'(bus.req_ready), 64'b0001);
        tick();
        check_out("release", 1'b1, 0, mk(0, 32'h10));

        // Idle hold after a single broadcast
        pkt[1] = mk(5, 32'hDEADBEEF);
        drive(4'b0010);
        check_eq("hold_ready", 64'(bus.req_ready), 64'b0010);
        tick();
        check_out("hold_pulse", 1'b1, 1, mk(5, 32'hDEADBEEF));
        drive(4'b0000);
        tick();
        check_out("hold1", 1'b0, 1, mk(5, 32'hDEADBEEF));
        tick();
        check_out("hold2", 1'b0, 1, mk(5, 32'hDEADBEEF));

        // Mid-operation reset: ptr would be 3 without reset
        drive(4'b0100);
        check_eq("mid_ready", 64'(bus.req_ready), 64'b0100);
        tick();
        check_out("mid_grant", 1'b1, 2, mk(2, 32'h12));
        rst = 1'b1;
        drive(4'b0001);
        check_eq("mid_rst_ready", 64'(bus.req_ready), 64'h0);
        tick();
        check_out("mid_rst", 1'b0, 0, '0);
        rst = 1'b0;
        drive(4'b1001);
        check_eq("post_rst_ready", 64'(bus.req_ready), 64'b0001);
        tick();
        check_out("post_rst", 1'b1, 0, mk(0, 32'h10));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
